wind_direction_xy: RTL and testbench

- Main signal-processing path of the ultrasonic wind sensor.
- Takes four 12-bit acoustic receiver signals sampled at 100 kHz (one `endata` pulse per 20 clocks at 2 MHz).
- For each axis, measures the phase of the upwind signal relative to the downwind signal with a Hilbert-filter quadrature detector averaged over 2^`spdmeanlen` samples.
- Converts each phase to a signed wind speed, Q6.10.

---
 rtl/wind_direction_xy.sv | 276 +++++++++++++++++++++++++++
 tb/tb_wind_direction_xy.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wind_direction_xy.sv
// ---------------------------------------------------------------------------
// wind_direction_xy
//
// Main signal-processing path of the ultrasonic wind sensor. For each axis
// the upwind receiver (B) is phase-compared with the downwind receiver (A):
// a Hilbert FIR on A gives a quadrature reference, I = sum(Ad*Bd) and
// Q = sum(HA*Bd) are averaged over 2^L samples, phi = atan2(Qm, Im) is
// found by a 16-step vectoring CORDIC and scaled to a signed Q6.10 speed.
//
// Ports
//   clock       system clock (2 MHz), rising edge
//   reset       synchronous, active-low
//   endata      one-clock sample strobe; rx1..rx4 sampled while high
//   rx1         signed 12-bit, downwind Y (top receiver)
//   rx2         signed 12-bit, upwind X (left receiver)
//   rx3         signed 12-bit, upwind Y (bottom receiver)
//   rx4         signed 12-bit, downwind X (right receiver)
//   spdmeanlen  log2 of averaging length, clamped to 6..11 per window
//   speedX      signed X wind speed, 10 fractional bits
//   speedY      signed Y wind speed, 10 fractional bits
//   speeden     one-clock pulse when speedX/speedY update
// ---------------------------------------------------------------------------
module wind_direction_xy #(
    parameter int MAXSIMDATA = 2000,
    parameter int KSPEED     = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        endata,
    input  logic [11:0] rx1,
    input  logic [11:0] rx2,
    input  logic [11:0] rx3,
    input  logic [11:0] rx4,
    input  logic [3:0]  spdmeanlen,
    output logic [15:0] speedX,
    output logic [15:0] speedY,
    output logic        speeden
);

    if (MAXSIMDATA < 1) begin : g_bad_maxsimdata
        $error("MAXSIMDATA must be positive");
    end

    localparam int AW = 37;   // accumulator width
    localparam int CW = 40;   // CORDIC x/y width (headroom for gain 1.647)
    localparam int ZW = 18;   // CORDIC angle width, Q13 radians
    localparam int SW = 52;   // speed product width

    localparam logic signed [ZW-1:0] HALF_PI = 18'sd12868;
    localparam logic signed [ZW-1:0] PI_Q13  = 18'sd25736;
    localparam logic signed [ZW-1:0] NEG_PI  = -18'sd25736;
    localparam logic signed [SW-1:0] SPD_MAX = SW'(32767);
    localparam logic signed [SW-1:0] SPD_MIN = -SW'(32768);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_ITER,
        ST_OUT
    } state_t;

    state_t state;

    // Tap 0 of the 7-sample window is the live input; registers hold taps
    // 1..6 for A and taps 1..3 for B (only b3 is ever used).
    logic signed [11:0]   hist_a [2][6];
    logic signed [11:0]   hist_b [2][3];
    logic signed [AW-1:0] acc_i  [2];
    logic signed [AW-1:0] acc_q  [2];
    logic signed [AW-1:0] mean_i [2];
    logic signed [AW-1:0] mean_q [2];
    logic [10:0]          cnt;
    logic [3:0]           win_len;

    logic signed [CW-1:0] cx [2];
    logic signed [CW-1:0] cy [2];
    logic signed [ZW-1:0] cz [2];
    logic                 zero_in [2];
    logic [3:0]           iter;

    // combinational datapath
    logic signed [11:0]   new_a  [2];
    logic signed [11:0]   new_b  [2];
    logic signed [23:0]   hsum   [2];
    logic signed [12:0]   ha     [2];
    logic signed [AW-1:0] prod_i [2];
    logic signed [AW-1:0] prod_q [2];
    logic signed [AW-1:0] sum_i  [2];
    logic signed [AW-1:0] sum_q  [2];
    logic signed [CW-1:0] xsh    [2];
    logic signed [CW-1:0] ysh    [2];
    logic signed [ZW-1:0] phi    [2];
    logic signed [SW-1:0] scaled [2];
    logic signed [15:0]   spd    [2];
    logic [3:0]           len_now;
    logic                 last;
    logic signed [ZW-1:0] atan_i;

    always_comb begin
        new_a[0] = $signed(rx4);
        new_b[0] = $signed(rx2);
        new_a[1] = $signed(rx1);
        new_b[1] = $signed(rx3);

        // Window length is captured on the first sample of a window.
        if (cnt == 11'd0) begin
            if (spdmeanlen < 4'd6)
                len_now = 4'd6;
            else if (spdmeanlen > 4'd11)
                len_now = 4'd11;
            else
                len_now = spdmeanlen;
        end else begin
            len_now = win_len;
        end
        last = ({1'b0, cnt} == ((12'd1 << len_now) - 12'd1));

        for (int unsigned ax = 0; ax < 2; ax++) begin
            // -217*a0 - 652*a2 + 652*a4 + 217*a6, grouped by coefficient
            hsum[ax] = 24'sd217 * (24'(hist_a[ax][5]) - 24'(new_a[ax]))
                     + 24'sd652 * (24'(hist_a[ax][3]) - 24'(hist_a[ax][1]));
            ha[ax]     = 13'((hsum[ax] + 24'sd512) >>> 10);
            prod_i[ax] = AW'(hist_a[ax][2]) * AW'(hist_b[ax][2]);
            prod_q[ax] = AW'(ha[ax]) * AW'(hist_b[ax][2]);
            sum_i[ax]  = acc_i[ax] + prod_i[ax];
            sum_q[ax]  = acc_q[ax] + prod_q[ax];

            xsh[ax] = cx[ax] >>> iter;
            ysh[ax] = cy[ax] >>> iter;

            if (zero_in[ax])
                phi[ax] = '0;
            else if (cz[ax] > PI_Q13)
                phi[ax] = PI_Q13;
            else if (cz[ax] < NEG_PI)
                phi[ax] = NEG_PI;
            else
                phi[ax] = cz[ax];

            scaled[ax] = (SW'(phi[ax]) * SW'(KSPEED)) >>> 13;
            if (scaled[ax] > SPD_MAX)
                spd[ax] = 16'sh7FFF;
            else if (scaled[ax] < SPD_MIN)
                spd[ax] = 16'sh8000;
            else
                spd[ax] = 16'(scaled[ax]);
        end
    end

    // atan(2^-i) in Q13 radians
    always_comb begin
        case (iter)
            4'd0:    atan_i = 18'sd6434;
            4'd1:    atan_i = 18'sd3798;
            4'd2:    atan_i = 18'sd2007;
            4'd3:    atan_i = 18'sd1019;
            4'd4:    atan_i = 18'sd511;
            4'd5:    atan_i = 18'sd256;
            4'd6:    atan_i = 18'sd128;
            4'd7:    atan_i = 18'sd64;
            4'd8:    atan_i = 18'sd32;
            4'd9:    atan_i = 18'sd16;
            4'd10:   atan_i = 18'sd8;
            4'd11:   atan_i = 18'sd4;
            4'd12:   atan_i = 18'sd2;
            4'd13:   atan_i = 18'sd1;
            4'd14:   atan_i = 18'sd1;
            default: atan_i = 18'sd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= ST_IDLE;
            iter    <= '0;
            cnt     <= '0;
            win_len <= 4'd6;
            speedX  <= '0;
            speedY  <= '0;
            speeden <= 1'b0;
            for (int unsigned ax = 0; ax < 2; ax++) begin
                acc_i[ax]   <= '0;
                acc_q[ax]   <= '0;
                mean_i[ax]  <= '0;
                mean_q[ax]  <= '0;
                cx[ax]      <= '0;
                cy[ax]      <= '0;
                cz[ax]      <= '0;
                zero_in[ax] <= 1'b0;
                for (int unsigned k = 0; k < 6; k++)
                    hist_a[ax][k] <= '0;
                for (int unsigned k = 0; k < 3; k++)
                    hist_b[ax][k] <= '0;
            end
        end else begin
            speeden <= 1'b0;

            if (endata) begin
                if (cnt == 11'd0)
                    win_len <= len_now;
                for (int unsigned ax = 0; ax < 2; ax++) begin
                    for (int unsigned k = 5; k > 0; k--)
                        hist_a[ax][k] <= hist_a[ax][k-1];
                    hist_a[ax][0] <= new_a[ax];
                    for (int unsigned k = 2; k > 0; k--)
                        hist_b[ax][k] <= hist_b[ax][k-1];
                    hist_b[ax][0] <= new_b[ax];
                    // The closing sample is folded into the mean directly.
                    if (last) begin
                        mean_i[ax] <= sum_i[ax] >>> len_now;
                        mean_q[ax] <= sum_q[ax] >>> len_now;
                        acc_i[ax]  <= '0;
                        acc_q[ax]  <= '0;
                    end else begin
                        acc_i[ax]  <= sum_i[ax];
                        acc_q[ax]  <= sum_q[ax];
                    end
                end
                cnt <= last ? 11'd0 : cnt + 11'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (endata && last)
                        state <= ST_PRE;
                end
                ST_PRE: begin
                    // Fold the left half-plane into the right so the
                    // CORDIC only has to cover +-pi/2.
                    for (int unsigned ax = 0; ax < 2; ax++) begin
                        zero_in[ax] <= (mean_i[ax] == '0) && (mean_q[ax] == '0);
                        if (!mean_i[ax][AW-1]) begin
                            cx[ax] <= CW'(mean_i[ax]);
                            cy[ax] <= CW'(mean_q[ax]);
                            cz[ax] <= '0;
                        end else if (!mean_q[ax][AW-1]) begin
                            cx[ax] <= CW'(mean_q[ax]);
                            cy[ax] <= -CW'(mean_i[ax]);
                            cz[ax] <= HALF_PI;
                        end else begin
                            cx[ax] <= -CW'(mean_q[ax]);
                            cy[ax] <= CW'(mean_i[ax]);
                            cz[ax] <= -HALF_PI;
                        end
                    end
                    iter  <= '0;
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    for (int unsigned ax = 0; ax < 2; ax++) begin
                        if (!cy[ax][CW-1]) begin
                            cx[ax] <= cx[ax] + ysh[ax];
                            cy[ax] <= cy[ax] - xsh[ax];
                            cz[ax] <= cz[ax] + atan_i;
                        end else begin
                            cx[ax] <= cx[ax] - ysh[ax];
                            cy[ax] <= cy[ax] + xsh[ax];
                            cz[ax] <= cz[ax] - atan_i;
                        end
                    end
                    iter <= iter + 4'd1;
                    if (iter == 4'd15)
                        state <= ST_OUT;
                end
                ST_OUT: begin
                    speedX  <= spd[0];
                    speedY  <= spd[1];
                    speeden <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wind_direction_xy.sv
module tb_wind_direction_xy;

    logic        clock      = 1'b0;
    logic        reset      = 1'b0;
    logic        endata     = 1'b0;
    logic [11:0] rx1        = '0;
    logic [11:0] rx2        = '0;
    logic [11:0] rx3        = '0;
    logic [11:0] rx4        = '0;
    logic [3:0]  spdmeanlen = 4'd6;
    logic [15:0] speedX, speedY, speedX_s, speedY_s;
    logic        speeden, speeden_s;

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;

    typedef struct {
        longint due;
        int     ex;
        int     ey;
        int     sx;
        int     sy;
    } exp_t;

    exp_t   sbq[$];
    exp_t   mon_e;

    // reference model state
    int     hA [2][6];
    int     hB [2][6];
    longint accI [2];
    longint accQ [2];
    int     mcnt = 0;
    int     mL   = 6;
    int     m    = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    wind_direction_xy #(.MAXSIMDATA(2000), .KSPEED(1024)) dut (
        .clock(clock), .reset(reset), .endata(endata),
        .rx1(rx1), .rx2(rx2), .rx3(rx3), .rx4(rx4),
        .spdmeanlen(spdmeanlen),
        .speedX(speedX), .speedY(speedY), .speeden(speeden)
    );

    wind_direction_xy #(.MAXSIMDATA(2000), .KSPEED(32767)) dut_sat (
        .clock(clock), .reset(reset), .endata(endata),
        .rx1(rx1), .rx2(rx2), .rx3(rx3), .rx4(rx4),
        .spdmeanlen(spdmeanlen),
        .speedX(speedX_s), .speedY(speedY_s), .speeden(speeden_s)
    );

    function automatic int cq(input int n);
        case (n & 3)
            0:       return 1000;
            2:       return -1000;
            default: return 0;
        endcase
    endfunction

    function automatic int clampL(input int v);
        if (v < 6)  return 6;
        if (v > 11) return 11;
        return v;
    endfunction

    function automatic int exp_speed(input longint im, input longint qm, input int k);
        real phi;
        real s;
        if (im == 0 && qm == 0) return 0;
        phi = $atan2(real'(qm), real'(im));
        s = $floor(phi * real'(k));
        if (s > 32767.0)  return 32767;
        if (s < -32768.0) return -32768;
        return int'(s);
    endfunction

    task automatic chk_eq(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp)
            else begin
                bad++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
        total++;
        assert (((obs - exp) <= tol) && ((exp - obs) <= tol))
            else begin
                bad++;
                $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
            end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        for (int ax = 0; ax < 2; ax++) begin
            for (int k = 0; k < 6; k++) begin
                hA[ax][k] = 0;
                hB[ax][k] = 0;
            end
            accI[ax] = 0;
            accQ[ax] = 0;
        end
        mcnt = 0;
        sbq.delete();
    endtask

    task automatic model_sample(input int xa, input int xb, input int ya, input int yb);
        int     a [2];
        int     b [2];
        longint ha;
        longint im [2];
        longint qm [2];
        exp_t   e;
        a[0] = xa; b[0] = xb;
        a[1] = ya; b[1] = yb;
        if (mcnt == 0) mL = clampL(int'(spdmeanlen));
        for (int ax = 0; ax < 2; ax++) begin
            ha = (longint'(-217 * a[ax]) - longint'(652 * hA[ax][1])
                  + longint'(652 * hA[ax][3]) + longint'(217 * hA[ax][5]) + 512) >>> 10;
            accI[ax] += longint'(hA[ax][2]) * longint'(hB[ax][2]);
            accQ[ax] += ha * longint'(hB[ax][2]);
            for (int k = 5; k > 0; k--) begin
                hA[ax][k] = hA[ax][k-1];
                hB[ax][k] = hB[ax][k-1];
            end
            hA[ax][0] = a[ax];
            hB[ax][0] = b[ax];
        end
        mcnt++;
        if (mcnt == (1 << mL)) begin
            for (int ax = 0; ax < 2; ax++) begin
                im[ax]   = accI[ax] >>> mL;
                qm[ax]   = accQ[ax] >>> mL;
                accI[ax] = 0;
                accQ[ax] = 0;
            end
            e.due = cyc + 19;
            e.ex  = exp_speed(im[0], qm[0], 1024);
            e.ey  = exp_speed(im[1], qm[1], 1024);
            e.sx  = exp_speed(im[0], qm[0], 32767);
            e.sy  = exp_speed(im[1], qm[1], 32767);
            sbq.push_back(e);
            mcnt = 0;
        end
    endtask

    // xa->rx4, xb->rx2, ya->rx1, yb->rx3; one sample every 20 clocks
    task automatic send(input int xa, input int xb, input int ya, input int yb);
        rx4    = 12'(xa);
        rx2    = 12'(xb);
        rx1    = 12'(ya);
        rx3    = 12'(yb);
        endata = 1'b1;
        model_sample(xa, xb, ya, yb);
        tick();
        endata = 1'b0;
        repeat (19) tick();
    endtask

    always @(negedge clock) begin
        if (speeden === 1'b1 || speeden_s === 1'b1) begin
            total++;
            assert (sbq.size() > 0)
                else begin
                    bad++;
                    $error("FAIL unexpected_speeden cycle=%0d observed=1 expected=0", cyc);
                end
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk_eq("speeden_latency", cyc, mon_e.due);
                chk_eq("speeden_pair", longint'(speeden_s), longint'(speeden));
                chk_tol("speedX", int'($signed(speedX)), mon_e.ex, 2);
                chk_tol("speedY", int'($signed(speedY)), mon_e.ey, 2);
                chk_tol("speedX_k32767", int'($signed(speedX_s)), mon_e.sx, 16);
                chk_tol("speedY_k32767", int'($signed(speedY_s)), mon_e.sy, 16);
            end
        end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
            total++;
            assert (speeden === 1'b1)
                else begin
                    bad++;
                    $error("FAIL speeden_timeout cycle=%0d observed=0 expected=1 due=%0d", cyc, sbq[0].due);
                end
            void'(sbq.pop_front());
        end
    end

    initial begin
        model_reset();
        repeat (3) tick();
        chk_eq("reset_speedX", longint'($signed(speedX)), 0);
        chk_eq("reset_speedY", longint'($signed(speedY)), 0);
        chk_eq("reset_speeden", longint'(speeden), 0);
        chk_eq("reset_speedX_k32767", longint'($signed(speedX_s)), 0);
        reset = 1'b1;
        tick();

        // silence, L=6
        repeat (128) send(0, 0, 0, 0);

        // identical cosines on both axes: phase 0
        repeat (128) begin send(cq(m), cq(m), cq(m), cq(m)); m++; end

        // X upwind lags by one sample: +pi/2
        repeat (128) begin send(cq(m), cq(m-1), cq(m), cq(m)); m++; end

        // X roles swapped: -pi/2
        repeat (128) begin send(cq(m-1), cq(m), cq(m), cq(m)); m++; end

        // X inverted (phi = pi, saturates with KSPEED=32767), Y lags: +pi/2
        repeat (128) begin send(cq(m), -cq(m), cq(m), cq(m-1)); m++; end

        // 2048-sample window, then a clamped 64-sample one
        spdmeanlen = 4'd11;
        repeat (10) begin send(cq(m), cq(m-1), cq(m), cq(m)); m++; end
        spdmeanlen = 4'd3;
        repeat (2038 + 64) begin send(cq(m), cq(m-1), cq(m), cq(m)); m++; end

        // short reset mid-window discards the partial window
        repeat (30) begin send(cq(m), cq(m-1), cq(m), cq(m)); m++; end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        chk_eq("midreset_speedX", longint'($signed(speedX)), 0);
        chk_eq("midreset_speedY", longint'($signed(speedY)), 0);
        chk_eq("midreset_speeden", longint'(speeden), 0);
        repeat (64) begin send(cq(m-1), cq(m), cq(m), cq(m-1)); m++; end

        repeat (40) tick();
        chk_eq("scoreboard_drained", longint'(sbq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
